// File: rtl/cpu_defs.sv
// Shared definitions for the fetch stage.
// Contents: default NOP word and reset PC, decode control-bus field indices,
// the fetch-entry record held in the prefetch queue, and a word-align helper.
package cpu_defs;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // Decode -> fetch control bus layout. Bit 32 is reserved and ignored.
   localparam int CTR_W       = 35;
   localparam int CTR_STALL   = 34;
   localparam int CTR_REDIR   = 33;
   localparam int CTR_TGT_MSB = 31;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Instruction addresses are word aligned; low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction memory and decode.
// master: the fetch unit (drives imem_en/imem_addr and the inst* outputs,
//         receives ctrbus, over and imem_rdata).
// slave : the surrounding pipeline/memory (opposite directions).
interface fetch_prefetch_unit_if;
   import cpu_defs::*;

   logic [CTR_W-1:0] ctrbus;      // [34]=stall [33]=redirect [31:0]=target
   logic             over;        // halt request from the memory stage
   logic             imem_en;     // instruction memory read strobe
   logic [31:0]      imem_addr;   // word-aligned read address
   logic [31:0]      imem_rdata;  // read data, one cycle after imem_en
   logic [31:0]      inst;        // instruction presented to decode
   logic             inst_valid;  // inst is a real instruction
   logic [31:0]      inst_pc;     // address of inst, 0 when not valid

   modport master (
      input  ctrbus, over, imem_rdata,
      output imem_en, imem_addr, inst, inst_valid, inst_pc
   );

   modport slave (
      output ctrbus, over, imem_rdata,
      input  imem_en, imem_addr, inst, inst_valid, inst_pc
   );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries sitting between instruction memory and decode.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   flush             discard every entry (wins over push/pop)
//   push, push_entry  write one entry at the tail
//   pop               drop the head entry
//   head              current head entry (meaningless when empty)
//   count             number of stored entries, 0..DEPTH
//   empty             no entries stored
// DEPTH must be a power of two so the pointers wrap without extra logic.
module fetch_queue
   import cpu_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   store [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [CW-1:0]  count_q;
   logic           full;

   // NOTE: non-blocking assignments on every clocked register so all state
   // updates at an edge see the pre-edge values, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the entry storage has no reset; an entry is only ever read after
   // it was written, so clearing it would buy nothing but reset fan-out.
   always_ff @(posedge clk) begin
      if (push && !flush) store[wr_ptr] <= push_entry;
   end

   assign head  = store[rd_ptr];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // The issue logic reserves a slot for every outstanding read, so a push
   // into a full queue means that reservation is broken.
   overflow_a: assert property (@(posedge clk) disable iff (!reset)
                                !(push && full));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage with a small prefetch queue.
// Owns the PC, issues sequential reads to a synchronous instruction memory,
// buffers returned words and presents the queue head to decode.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    fetch_prefetch_unit_if.master: ctrbus/over from the pipeline,
//          imem_en/imem_addr/imem_rdata to memory, inst/inst_valid/inst_pc
//          to decode
// Parameters: RESET_PC, DEPTH (power of two, >= 2), NOP_WORD.
module fetch_prefetch_unit #(
   parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = cpu_defs::NOP_WORD
) (
   input  logic                   clk,
   input  logic                   reset,
   fetch_prefetch_unit_if.master  bus
);
   import cpu_defs::*;

   localparam int CW = $clog2(DEPTH) + 1;

   // Control bus fields
   logic        stall;
   logic        redir;
   logic [31:0] target;
   logic        ctr_unused;

   assign stall      = bus.ctrbus[CTR_STALL];
   assign redir      = bus.ctrbus[CTR_REDIR];
   assign target     = bus.ctrbus[CTR_TGT_MSB:0];
   assign ctr_unused = bus.ctrbus[32];

   // Fetch state
   logic        [31:0] pc;
   logic               epoch;
   logic               halted;
   logic               inflight;
   logic        [31:0] inflight_pc;
   logic               inflight_epoch;

   // Queue side
   fetch_entry_t       q_head;
   fetch_entry_t       ret_entry;
   logic      [CW-1:0] q_count;
   logic               q_empty;

   logic frozen;
   logic redirect_take;
   logic issue;
   logic push;
   logic pop;
   logic head_valid;

   // Halt acts in the same cycle over rises, and stays after it drops.
   assign frozen        = halted | bus.over;
   assign redirect_take = redir & ~frozen;

   // count + inflight counts every word already owed a queue slot, so a new
   // read is only started when its slot is guaranteed. Reset blocks issue
   // combinationally because the strobe must stay low throughout reset.
   assign issue = reset & ~frozen & ~redir
                & ((q_count + CW'(inflight)) < CW'(DEPTH));

   // A return is kept only if no redirect happened since it was issued and
   // nothing is flushing or freezing the queue this cycle.
   assign push = inflight & (inflight_epoch == epoch) & ~frozen & ~redirect_take;

   assign head_valid = ~q_empty & ~frozen;
   assign pop        = head_valid & ~stall & ~redir;

   assign ret_entry = '{pc: inflight_pc, inst: bus.imem_rdata};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc             <= RESET_PC;
         epoch          <= 1'b0;
         halted         <= 1'b0;
         inflight       <= 1'b0;
         inflight_pc    <= '0;
         inflight_epoch <= 1'b0;
      end else begin
         if (bus.over) halted <= 1'b1;

         if (redirect_take) begin
            pc    <= word_align(target);
            epoch <= ~epoch;
         end else if (issue) begin
            pc    <= pc + 32'd4;
         end

         inflight <= issue;
         if (issue) begin
            inflight_pc    <= pc;
            inflight_epoch <= epoch;
         end
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_take),
      .push       (push),
      .push_entry (ret_entry),
      .pop        (pop),
      .head       (q_head),
      .count      (q_count),
      .empty      (q_empty)
   );

   assign bus.imem_en    = issue;
   assign bus.imem_addr  = pc;
   assign bus.inst_valid = head_valid;
   assign bus.inst       = head_valid ? q_head.inst : NOP_WORD;
   assign bus.inst_pc    = head_valid ? q_head.pc   : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit. A reference model tracks the
// words issued and not yet consumed; a word becomes visible two cycles after
// its issue, decode consumes it when not stalling, redirects discard all.
module tb_fetch_prefetch_unit;
   import cpu_defs::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;

   fetch_prefetch_unit_if bus ();

   fetch_prefetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH),
      .NOP_WORD (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: word = address ^ salt.
   logic [31:0] salt = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ salt;
   endfunction

   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
   end

   int total = 0;
   int bad   = 0;

   // Reference model state
   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } issued_t;

   issued_t     m_q[$];
   logic [31:0] m_fetch_pc;
   bit          m_halted;
   int          now = 0;

   logic        exp_en, exp_valid;
   logic [31:0] exp_addr, exp_inst, exp_pc;
   logic        obs_en, obs_valid;
   logic [31:0] obs_addr, obs_inst, obs_pc;

   task automatic model_reset();
      m_q.delete();
      m_fetch_pc = RST_PC;
      m_halted   = 1'b0;
   endtask

   // One clock cycle: called 1 time unit after a rising edge, drives inputs,
   // samples outputs and model expectations at the falling edge, advances the
   // model at the rising edge and returns 1 time unit later.
   task automatic cycle(input bit st, input bit rd, input logic [31:0] tg, input bit ov);
      bit frozen;
      bus.ctrbus = {st, rd, 1'b0, tg};
      bus.over   = ov;
      @(negedge clk);
      frozen    = m_halted || ov;
      exp_en    = !frozen && !rd && (m_q.size() < DEPTH);
      exp_addr  = m_fetch_pc;
      exp_valid = !frozen && (m_q.size() > 0) && (m_q[0].cyc <= now - 2);
      exp_pc    = exp_valid ? m_q[0].pc : 32'h0;
      exp_inst  = exp_valid ? mem_word(m_q[0].pc) : NOP;
      obs_en    = bus.imem_en;
      obs_addr  = bus.imem_addr;
      obs_valid = bus.inst_valid;
      obs_inst  = bus.inst;
      obs_pc    = bus.inst_pc;
      @(posedge clk);
      if (ov) m_halted = 1'b1;
      if (!frozen) begin
         if (rd) begin
            m_q.delete();
            m_fetch_pc = tg & 32'hFFFF_FFFC;
         end else begin
            if (exp_valid && !st) void'(m_q.pop_front());
            if (exp_en) begin
               m_q.push_back('{pc: m_fetch_pc, cyc: now});
               m_fetch_pc = m_fetch_pc + 32'd4;
            end
         end
      end
      now++;
      #1;
   endtask

   task automatic do_reset(input logic [31:0] new_salt);
      reset      = 1'b0;
      bus.ctrbus = '0;
      bus.over   = 1'b0;
      @(posedge clk);
      salt = new_salt;
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      bus.ctrbus = '0;
      bus.over   = 1'b0;
      #3;
      total += 5;
      if (bus.imem_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", bus.imem_en); end
      if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.inst_valid); end
      if (bus.inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h want=%h", bus.inst, NOP); end
      if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.inst_pc); end
      if (bus.imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", bus.imem_addr, RST_PC); end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_stream();
      int first_issue = -1;
      int first_valid = -1;
      logic [31:0] want_fetch = RST_PC;
      logic [31:0] want_inst  = RST_PC;
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         total++;
         if (obs_en !== exp_en) begin bad++; $display("FAIL stream_en k=%0d got=%b want=%b", k, obs_en, exp_en); end
         if (obs_en === 1'b1) begin
            if (first_issue < 0) first_issue = k;
            total++;
            if (obs_addr !== want_fetch) begin bad++; $display("FAIL stream_addr k=%0d got=%h want=%h", k, obs_addr, want_fetch); end
            want_fetch = want_fetch + 32'd4;
         end
         if (obs_valid === 1'b1) begin
            if (first_valid < 0) first_valid = k;
            total++;
            if (obs_pc !== want_inst || obs_inst !== want_inst) begin
               bad++; $display("FAIL stream_inst k=%0d got pc=%h inst=%h want=%h", k, obs_pc, obs_inst, want_inst);
            end
            want_inst = want_inst + 32'd4;
         end
      end
      total += 2;
      if (first_issue !== 0) begin bad++; $display("FAIL stream_first_issue got=%0d want=0", first_issue); end
      if (first_valid !== first_issue + 2) begin bad++; $display("FAIL stream_latency got=%0d want=%0d", first_valid, first_issue + 2); end
   endtask

   task automatic test_stall();
      int          n;
      bit          found = 1'b0;
      logic [31:0] want;
      for (int k = 0; k < 10 && !found; k++) begin
         if (bus.inst_valid === 1'b1 && bus.inst_pc === 32'h10) found = 1'b1;
         else cycle(1'b0, 1'b0, 32'h0, 1'b0);
      end
      total++;
      if (!found) begin bad++; $display("FAIL stall_wait head 0x10 never seen"); end
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1'b0, 32'h0, 1'b0);
         total += 2;
         if (obs_valid !== 1'b1 || obs_pc !== 32'h10 || obs_inst !== 32'h10) begin
            bad++; $display("FAIL stall_hold k=%0d got v=%b pc=%h inst=%h want 0x10", k, obs_valid, obs_pc, obs_inst);
         end
         if (obs_en !== exp_en) begin bad++; $display("FAIL stall_en k=%0d got=%b want=%b", k, obs_en, exp_en); end
      end
      total++;
      if (obs_en !== 1'b0) begin bad++; $display("FAIL stall_issue_stop got=%b want=0", obs_en); end
      // Released: the held 0x10 is consumed, then 0x14 immediately, then 0x18.
      want = 32'h10;
      n = 0;
      for (int k = 0; k < 8 && want != 32'h1C; k++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         if (obs_valid === 1'b1) begin
            total++;
            if (obs_pc !== want || obs_inst !== want) begin bad++; $display("FAIL stall_release got=%h want=%h", obs_pc, want); end
            want = want + 32'd4;
         end
         if (k == 1) begin
            total++;
            if (obs_valid !== 1'b1 || obs_pc !== 32'h14) begin bad++; $display("FAIL stall_no_gap got v=%b pc=%h want 0x14", obs_valid, obs_pc); end
         end
         n++;
      end
      total++;
      if (want !== 32'h1C) begin bad++; $display("FAIL stall_release_timeout last=%h want=0x1c", want); end
   endtask

   task automatic test_redirect();
      bit found = 1'b0;
      do_reset(32'h0);
      for (int k = 0; k < 20 && !found; k++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         if (obs_en === 1'b1 && obs_addr === 32'h1C) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL redir_wait fetch of 0x1c never issued"); end
      cycle(1'b0, 1'b1, 32'h203, 1'b0);
      total += 2;
      if (obs_en !== 1'b0) begin bad++; $display("FAIL redir_no_issue got=%b want=0", obs_en); end
      if (obs_valid === 1'b1 && obs_pc === 32'h1C) begin bad++; $display("FAIL redir_stale_0 got pc=%h", obs_pc); end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total += 2;
      if (obs_en !== 1'b1 || obs_addr !== 32'h200) begin bad++; $display("FAIL redir_target_addr got en=%b addr=%h want 1/200", obs_en, obs_addr); end
      if (obs_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_1 got pc=%h valid=%b want invalid", obs_pc, obs_valid); end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (obs_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_2 got pc=%h valid=%b want invalid", obs_pc, obs_valid); end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h200 || obs_inst !== 32'h200) begin
         bad++; $display("FAIL redir_first_target got v=%b pc=%h inst=%h want 200", obs_valid, obs_pc, obs_inst);
      end
   endtask

   task automatic test_redirect_stall();
      bit found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         if (bus.inst_valid === 1'b1) found = 1'b1;
         else cycle(1'b0, 1'b0, 32'h0, 1'b0);
      end
      total++;
      if (!found) begin bad++; $display("FAIL rs_wait no valid head"); end
      cycle(1'b1, 1'b1, 32'h400, 1'b0);
      total++;
      if (obs_en !== 1'b0) begin bad++; $display("FAIL rs_no_issue got=%b want=0", obs_en); end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total += 2;
      if (obs_valid !== 1'b0) begin bad++; $display("FAIL rs_flushed got v=%b pc=%h want invalid", obs_valid, obs_pc); end
      if (obs_en !== 1'b1 || obs_addr !== 32'h400) begin bad++; $display("FAIL rs_target_addr got en=%b addr=%h want 1/400", obs_en, obs_addr); end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h400) begin bad++; $display("FAIL rs_first_target got v=%b pc=%h want 400", obs_valid, obs_pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] want_f [3];
      int nf = 0;
      int ni = 0;
      want_f[0] = 32'hFFFF_FFF8;
      want_f[1] = 32'hFFFF_FFFC;
      want_f[2] = 32'h0000_0000;
      cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
      for (int k = 0; k < 12 && (nf < 3 || ni < 3); k++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         if (obs_en === 1'b1 && nf < 3) begin
            total++;
            if (obs_addr !== want_f[nf]) begin bad++; $display("FAIL wrap_addr n=%0d got=%h want=%h", nf, obs_addr, want_f[nf]); end
            nf++;
         end
         if (obs_valid === 1'b1 && ni < 3) begin
            total++;
            if (obs_pc !== want_f[ni]) begin bad++; $display("FAIL wrap_inst n=%0d got=%h want=%h", ni, obs_pc, want_f[ni]); end
            ni++;
         end
      end
      total++;
      if (nf != 3 || ni != 3) begin bad++; $display("FAIL wrap_timeout fetched=%0d presented=%0d want 3/3", nf, ni); end
   endtask

   task automatic test_random();
      do_reset($urandom);
      for (int k = 0; k < 400; k++) begin
         if (k == 200) begin
            // Asynchronous reset in the middle of a cycle.
            #2;
            reset = 1'b0;
            #1;
            total++;
            if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== NOP) begin
               bad++; $display("FAIL rand_async_reset got en=%b v=%b inst=%h want 0/0/%h", bus.imem_en, bus.inst_valid, bus.inst, NOP);
            end
            @(posedge clk);
            #1;
            reset = 1'b1;
            model_reset();
         end
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom, 1'b0);
         total += 5;
         if (obs_en !== exp_en) begin bad++; $display("FAIL rand_en k=%0d got=%b want=%b", k, obs_en, exp_en); end
         if (obs_addr !== exp_addr) begin bad++; $display("FAIL rand_addr k=%0d got=%h want=%h", k, obs_addr, exp_addr); end
         if (obs_valid !== exp_valid) begin bad++; $display("FAIL rand_valid k=%0d got=%b want=%b", k, obs_valid, exp_valid); end
         if (obs_pc !== exp_pc) begin bad++; $display("FAIL rand_pc k=%0d got=%h want=%h", k, obs_pc, exp_pc); end
         if (obs_inst !== exp_inst) begin bad++; $display("FAIL rand_inst k=%0d got=%h want=%h", k, obs_inst, exp_inst); end
      end
   endtask

   task automatic test_halt();
      bit found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (bus.inst_valid === 1'b1) found = 1'b1;
         else cycle(1'b0, 1'b0, 32'h0, 1'b0);
      end
      total++;
      if (!found) begin bad++; $display("FAIL halt_wait no valid head"); end
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      total++;
      if (obs_en !== 1'b0 || obs_valid !== 1'b0 || obs_inst !== NOP) begin
         bad++; $display("FAIL halt_over got en=%b v=%b inst=%h want 0/0/%h", obs_en, obs_valid, obs_inst, NOP);
      end
      for (int k = 0; k < 20; k++) begin
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom, 1'b0);
         total++;
         if (obs_en !== 1'b0 || obs_valid !== 1'b0) begin
            bad++; $display("FAIL halt_sticky k=%0d got en=%b v=%b want 0/0", k, obs_en, obs_valid);
         end
      end
      do_reset(32'h0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (obs_en !== 1'b1 || obs_addr !== RST_PC) begin bad++; $display("FAIL halt_restart got en=%b addr=%h want 1/%h", obs_en, obs_addr, RST_PC); end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (obs_valid !== 1'b1 || obs_pc !== RST_PC) begin bad++; $display("FAIL halt_restart_inst got v=%b pc=%h want 1/%h", obs_valid, obs_pc, RST_PC); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_wrap();
      test_random();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
